// File: rtl/memory_arbiter.sv
// Two-requester round-robin arbiter in front of one shared memory port.
// Reads wait for memoryReady (bounded by TIMEOUT_CYCLES); writes take one bus cycle.
module memory_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0Enable,
  input  logic        req0ReadWrite,
  input  logic [31:0] req0Address,
  input  logic [31:0] req0WriteData,
  output logic [31:0] req0ReadData,
  output logic        req0Ready,
  input  logic        req1Enable,
  input  logic        req1ReadWrite,
  input  logic [31:0] req1Address,
  input  logic [31:0] req1WriteData,
  output logic [31:0] req1ReadData,
  output logic        req1Ready,
  inout  wire  [31:0] memoryData,
  input  logic        memoryReady,
  output logic        memoryEnable,
  output logic        memoryReadWrite,
  output logic [31:0] memoryAddress,
  output logic        busError,
  output logic        grant
);

  localparam logic RW_WRITE = 1'b1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RELEASE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             en_q, en_d;
  logic             rw_q, rw_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             drive_q, drive_d;
  logic             grant_q, grant_d;
  logic             last_grant_q, last_grant_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rdata0_q, rdata0_d;
  logic [31:0]      rdata1_q, rdata1_d;
  logic             rdy0_q, rdy0_d;
  logic             rdy1_q, rdy1_d;
  logic             bus_err_q, bus_err_d;
  logic             win_s;
  logic             sel_rw_s;
  logic             done_s;

  // On a tie the requester that did not win last time gets the bus.
  function automatic logic pick_winner(input logic r0, input logic r1, input logic last);
    logic w;
    if (r0 && r1) begin
      w = ~last;
    end else if (r1) begin
      w = 1'b1;
    end else begin
      w = 1'b0;
    end
    return w;
  endfunction

  assign memoryData      = drive_q ? wdata_q : 32'hzzzz_zzzz;
  assign memoryEnable    = en_q;
  assign memoryReadWrite = rw_q;
  assign memoryAddress   = addr_q;
  assign req0ReadData    = rdata0_q;
  assign req1ReadData    = rdata1_q;
  assign req0Ready       = rdy0_q;
  assign req1Ready       = rdy1_q;
  assign busError        = bus_err_q;
  assign grant           = grant_q;

  // Next-state and next-output logic for the IDLE/ACCESS/RELEASE sequence.
  always_comb begin
    state_d      = state_q;
    en_d         = en_q;
    rw_d         = rw_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    drive_d      = drive_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    rdy0_d       = 1'b0;
    rdy1_d       = 1'b0;
    bus_err_d    = 1'b0;
    done_s       = 1'b0;
    win_s        = pick_winner(req0Enable, req1Enable, last_grant_q);
    sel_rw_s     = win_s ? req1ReadWrite : req0ReadWrite;

    case (state_q)
      IDLE: begin
        if (req0Enable || req1Enable) begin
          state_d      = ACCESS;
          en_d         = 1'b1;
          grant_d      = win_s;
          last_grant_d = win_s;
          rw_d         = sel_rw_s;
          addr_d       = win_s ? req1Address : req0Address;
          wdata_d      = win_s ? req1WriteData : req0WriteData;
          drive_d      = (sel_rw_s == RW_WRITE);
          cnt_d        = {CNT_W{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        // memoryReady takes priority over a timeout landing in the same cycle.
        if (rw_q == RW_WRITE) begin
          done_s = 1'b1;
        end else if (memoryReady) begin
          done_s = 1'b1;
          if (grant_q) begin
            rdata1_d = memoryData;
          end else begin
            rdata0_d = memoryData;
          end
        end else if (cnt_q == CNT_LAST) begin
          done_s    = 1'b1;
          bus_err_d = 1'b1;
          if (grant_q) begin
            rdata1_d = 32'h0000_0000;
          end else begin
            rdata0_d = 32'h0000_0000;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end

        if (done_s) begin
          state_d = RELEASE;
          en_d    = 1'b0;
          drive_d = 1'b0;
          rdy0_d  = ~grant_q;
          rdy1_d  = grant_q;
        end else begin
          state_d = ACCESS;
        end
      end
      RELEASE: begin
        state_d = IDLE;
        en_d    = 1'b0;
        drive_d = 1'b0;
      end
      default: begin
        state_d = IDLE;
        en_d    = 1'b0;
        drive_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      en_q         <= 1'b0;
      rw_q         <= 1'b0;
      addr_q       <= 32'h0000_0000;
      wdata_q      <= 32'h0000_0000;
      drive_q      <= 1'b0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= {CNT_W{1'b0}};
      rdata0_q     <= 32'h0000_0000;
      rdata1_q     <= 32'h0000_0000;
      rdy0_q       <= 1'b0;
      rdy1_q       <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      en_q         <= en_d;
      rw_q         <= rw_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      drive_q      <= drive_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      rdy0_q       <= rdy0_d;
      rdy1_q       <= rdy1_d;
      bus_err_q    <= bus_err_d;
    end
  end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, max ACCESS cycles waiting for memoryReady before abort.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port req0Enable  input  1  requester 0 (core) access request, level.
REQ-005 SHALL have port req0ReadWrite  input  1  requester 0 direction, shared READ/WRITE encoding.
REQ-006 SHALL have port req0Address  input  32  requester 0 byte address.
REQ-007 SHALL have port req0WriteData  input  32  requester 0 store data.
REQ-008 SHALL have port req0ReadData  output  32  requester 0 load data, valid while req0Ready=1.
REQ-009 SHALL have port req0Ready  output  1  requester 0 completion pulse, one cycle.
REQ-010 SHALL have ports req1Enable, req1ReadWrite, req1Address, req1WriteData, req1ReadData, req1Ready, identical to REQ-004..009 for requester 1 (auxiliary/DMA).
REQ-011 SHALL have port memoryData  inout  32  shared memory data bus; driven only during a write access, else high-Z.
REQ-012 SHALL have port memoryReady  input  1  memory read-data-valid.
REQ-013 SHALL have port memoryEnable  output  1  memory access enable.
REQ-014 SHALL have port memoryReadWrite  output  1  memory direction.
REQ-015 SHALL have port memoryAddress  output  32  memory byte address.
REQ-016 SHALL have port busError  output  1  one-cycle pulse on timeout abort.
REQ-017 SHALL have port grant  output  1  index of requester owning current/last access.

Function
REQ-018 SHALL implement FSM states IDLE, ACCESS, RELEASE; all outputs registered.
REQ-019 IDLE: requests sampled only here; if any reqNEnable=1, latch winner's direction/address/writeData, set grant, go ACCESS next cycle; else stay IDLE.
REQ-020 Arbitration: single request wins; both requesting -> requester other than last granted wins (round-robin); lastGrant resets to 1 so requester 0 wins first tie.
REQ-021 ACCESS: memoryEnable=1, memoryAddress/memoryReadWrite hold latched values stable for whole access.
REQ-022 Write: memoryData driven with latched data; exactly one ACCESS cycle, then RELEASE with winner's ready pulse.
REQ-023 Read: stay in ACCESS until memoryReady=1 sampled at posedge; capture memoryData into winner's ReadData, go RELEASE with winner's ready pulse.
REQ-024 Timeout counter clears on entering ACCESS, increments each ACCESS cycle without memoryReady; reaching TIMEOUT_CYCLES -> RELEASE, winner's ReadData=32'h0, ready pulse and busError pulse same cycle.
REQ-025 memoryReady and timeout reached same cycle -> memoryReady wins, no busError.
REQ-026 RELEASE: memoryEnable=0, memoryData high-Z, exactly one cycle, then IDLE; guarantees one idle cycle between accesses so memory clears memoryReady.
REQ-027 reqNReady is high only in RELEASE, only for granted requester; non-granted ReadData holds previous value.
REQ-028 Requester shall drop Enable on the edge it samples Ready; Enable still high in IDLE is a new request.
REQ-029 Enable deasserted mid-access ignored; access completes.
REQ-030 memoryReady while not in ACCESS ignored.

Reset
REQ-031 reset=1 at posedge, any state: state=IDLE, memoryEnable=0, memoryReadWrite=READ, memoryAddress=0, memoryData high-Z, req0/1ReadData=0, req0/1Ready=0, busError=0, grant=0, lastGrant=1, counter=0; in-flight access abandoned, no ready pulse.

Verification
REQ-032 req0 read 0x0000_0010, memory returns 0xDEADBEEF after 4 cycles -> memoryEnable 5 cycles, req0Ready one pulse, req0ReadData=0xDEADBEEF, grant=0.
REQ-033 req1 write 0x0000_0020 data 0x12345678 -> one ACCESS cycle, memoryData=0x12345678 with WRITE, req1Ready pulse, then memoryEnable=0 one cycle.
REQ-034 both requesters read continuously after reset -> grants alternate 0,1,0,1; no back-to-back enable without RELEASE gap.
REQ-035 read with memoryReady never asserted, TIMEOUT_CYCLES=64 -> after 64 ACCESS cycles busError and req0Ready pulse together, req0ReadData=0.
REQ-036 reset asserted during read ACCESS cycle 2 -> next cycle memoryEnable=0, no ready pulse, IDLE; subsequent req1 tie request granted to requester 0.
